// File: rtl/count_binary_pio_in_pkg.sv
// Shared constants for the count_binary PIO input port: register map, edge modes
// and a constant-evaluable clog2 for sizing counters.
package count_binary_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/count_binary_pio_in_if.sv
// Avalon-MM slave bus of the PIO input port, including the level interrupt.
interface count_binary_pio_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/count_binary_pio_in_debounce.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional stable-count
// debouncer. With DEBOUNCE_CYCLES=0 the synchroniser output is passed straight through.
module count_binary_debounce
  import count_binary_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic dout_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_val;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign dout_o = sync_val;
  end else begin : g_debounce
    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync_val == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_d = sync_val;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign dout_o = deb_q;
  end

endmodule

// File: rtl/count_binary_pio_in.sv
// Parametrised PIO input port: per-bit sync/debounce, edge capture into a sticky
// W1C register, maskable level interrupt and a registered Avalon-MM read mux.
module count_binary_pio_in
  import count_binary_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_port,
  count_binary_pio_in_if.slave avs
);

  // Edges stay masked until the reset-cleared sync/debounce pipeline has caught up
  // with the pins, so an input already high at reset release is not seen as an edge.
  localparam int PRIME_CYCLES = SYNC_STAGES + 1 +
                                ((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES + 1 : 0);
  localparam int PW = clog2(PRIME_CYCLES + 1);
  localparam logic [PW-1:0] PRIME_LOAD = PW'(PRIME_CYCLES);

  logic [WIDTH-1:0] deb_val;
  logic [WIDTH-1:0] edge_prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic             primed;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    count_binary_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .din_i  (in_port[i]),
      .dout_o (deb_val[i])
    );
  end

  assign primed = (prime_q == '0);
  assign wr_en  = avs.chipselect & ~avs.write_n;

  always_comb begin
    raw_edge = deb_val & ~edge_prev_q;
    if (EDGE_MODE == int'(EDGE_FALLING)) raw_edge = ~deb_val & edge_prev_q;
    else if (EDGE_MODE == int'(EDGE_ANY)) raw_edge = deb_val ^ edge_prev_q;
    if (!primed) raw_edge = '0;
  end

  always_comb begin
    prime_d   = (prime_q != '0) ? prime_q - PW'(1) : prime_q;
    clr_mask  = '0;
    irqmask_d = irqmask_q;
    if (wr_en && avs.address == ADDR_EDGECAP) clr_mask  = avs.writedata[WIDTH-1:0];
    if (wr_en && avs.address == ADDR_IRQMASK) irqmask_d = avs.writedata[WIDTH-1:0];
    // New edges are OR-ed in after the clear so a same-cycle edge survives.
    edgecap_d = (edgecap_q & ~clr_mask) | raw_edge;
  end

  always_comb begin
    readdata_d = '0;
    if (avs.chipselect) begin
      case (avs.address)
        ADDR_DATA:    readdata_d = 32'(deb_val);
        ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
        ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_prev_q <= '0;
      irqmask_q   <= '0;
      edgecap_q   <= '0;
      readdata_q  <= '0;
      prime_q     <= PRIME_LOAD;
    end else begin
      edge_prev_q <= deb_val;
      irqmask_q   <= irqmask_d;
      edgecap_q   <= edgecap_d;
      readdata_q  <= readdata_d;
      prime_q     <= prime_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign avs.irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_count_binary_pio_in.sv
// Bench for count_binary_pio_in: three configurations on a shared bus, reads checked
// by a scoreboard one cycle after each request.
module tb_count_binary_pio_in;
  import count_binary_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rd;
  logic        wn;
  logic [31:0] wd;
  logic [2:0]  cs;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] in_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_binary_pio_in_if ifa ();
  count_binary_pio_in_if ifb ();
  count_binary_pio_in_if ifc ();

  assign ifa.address = addr;  assign ifa.read = rd;  assign ifa.write_n = wn;
  assign ifa.writedata = wd;  assign ifa.chipselect = cs[0];
  assign ifb.address = addr;  assign ifb.read = rd;  assign ifb.write_n = wn;
  assign ifb.writedata = wd;  assign ifb.chipselect = cs[1];
  assign ifc.address = addr;  assign ifc.read = rd;  assign ifc.write_n = wn;
  assign ifc.writedata = wd;  assign ifc.chipselect = cs[2];

  count_binary_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0))
    dut_a (.clk(clk), .reset(reset), .in_port(in_a), .avs(ifa));
  count_binary_pio_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0))
    dut_b (.clk(clk), .reset(reset), .in_port(in_b), .avs(ifb));
  count_binary_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2))
    dut_c (.clk(clk), .reset(reset), .in_port(in_c), .avs(ifc));

  typedef struct {
    int          d;
    logic [31:0] exp;
    bit          chk_irq;
    bit          exp_irq;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [31:0] rdata(input int d);
    case (d)
      0:       return ifa.readdata;
      1:       return ifb.readdata;
      default: return ifc.readdata;
    endcase
  endfunction

  function automatic logic irq_of(input int d);
    case (d)
      0:       return ifa.irq;
      1:       return ifb.irq;
      default: return ifc.irq;
    endcase
  endfunction

  // Monitor: a read issued in cycle k is answered right after edge k+1.
  logic rd_seen_q = 1'b0;
  always @(posedge clk) rd_seen_q <= rd;

  always @(negedge clk) begin
    if (rd_seen_q === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: read response with no expectation queued");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (rdata(e.d) !== e.exp) begin
          failures++;
          $display("FAIL %s: readdata=%h expected=%h", e.nm, rdata(e.d), e.exp);
        end
        if (e.chk_irq) begin
          checks++;
          if (irq_of(e.d) !== e.exp_irq) begin
            failures++;
            $display("FAIL %s_irq: irq=%b expected=%b", e.nm, irq_of(e.d), e.exp_irq);
          end
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input int d, input bit sel, input logic [1:0] a, input logic [31:0] exp,
                        input bit ci, input bit ei, input string nm);
    exp_t e;
    e.d = d; e.exp = exp; e.chk_irq = ci; e.exp_irq = ei; e.nm = nm;
    sb_q.push_back(e);
    addr = a;
    rd   = 1'b1;
    cs   = sel ? (3'b001 << d) : 3'b000;
    @(posedge clk);
    #1;
    rd = 1'b0;
    cs = 3'b000;
  endtask

  task automatic wr_req(input int d, input logic [1:0] a, input logic [31:0] data);
    addr = a;
    wd   = data;
    wn   = 1'b0;
    cs   = 3'b001 << d;
    @(posedge clk);
    #1;
    wn = 1'b1;
    cs = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; addr = '0; rd = 1'b0; wn = 1'b1; wd = '0; cs = '0;
    in_a = 8'hFF; in_b = 8'h00; in_c = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(10);

    // Reset state, with A's pins held high through release
    rd_req(0, 1, ADDR_EDGECAP, 32'h0,  1, 0, "a_rst_ecap");
    rd_req(0, 1, ADDR_DATA,    32'hFF, 1, 0, "a_rst_data");
    rd_req(0, 1, ADDR_IRQMASK, 32'h0,  0, 0, "a_rst_mask");
    rd_req(1, 1, ADDR_EDGECAP, 32'h0,  1, 0, "b_rst_ecap");
    rd_req(2, 1, ADDR_DATA,    32'h0,  1, 0, "c_rst_data");

    // A: rising-edge capture, W1C clear, upper writedata ignored
    wr_req(0, ADDR_IRQMASK, 32'hFFFF_FF01);
    rd_req(0, 1, ADDR_IRQMASK, 32'h01, 0, 0, "a_mask_trunc");
    in_a = 8'h00; cyc(6);
    rd_req(0, 1, ADDR_EDGECAP, 32'h0,  1, 0, "a_fall_ignored");
    in_a = 8'h01; cyc(4);
    rd_req(0, 1, ADDR_EDGECAP, 32'h1,  1, 1, "a_rise");
    rd_req(0, 1, ADDR_DATA,    32'h01, 0, 0, "a_data01");
    wr_req(0, ADDR_EDGECAP, 32'h1);
    rd_req(0, 1, ADDR_EDGECAP, 32'h0,  1, 0, "a_clear");

    // A: edge on bit 2 lands in the same cycle as its clear
    in_a = 8'h05; cyc(5);
    rd_req(0, 1, ADDR_EDGECAP, 32'h4,  1, 0, "a_bit2_set");
    in_a = 8'h01; cyc(5);
    in_a = 8'h05; cyc(2);
    wr_req(0, ADDR_EDGECAP, 32'h4);
    rd_req(0, 1, ADDR_EDGECAP, 32'h4,  0, 0, "a_set_wins");
    wr_req(0, ADDR_EDGECAP, 32'h4);
    rd_req(0, 1, ADDR_EDGECAP, 32'h0,  0, 0, "a_bit2_clear");

    // A: read protocol, reserved word, chipselect low
    wr_req(0, ADDR_RSVD, 32'hFFFF_FFFF);
    rd_req(0, 1, ADDR_DATA,    32'h05, 0, 0, "a_b2b_data");
    rd_req(0, 1, ADDR_RSVD,    32'h0,  0, 0, "a_b2b_rsvd");
    rd_req(0, 1, ADDR_IRQMASK, 32'h01, 0, 0, "a_b2b_mask");
    rd_req(0, 1, ADDR_EDGECAP, 32'h0,  0, 0, "a_b2b_ecap");
    rd_req(0, 0, ADDR_DATA,    32'h0,  0, 0, "a_cs_off");

    // B: debouncer rejects a 3-cycle pulse, accepts a held level after 2+4+1 cycles
    in_b = 8'h08; cyc(3);
    in_b = 8'h00; cyc(10);
    rd_req(1, 1, ADDR_DATA,    32'h0,  0, 0, "b_glitch_data");
    rd_req(1, 1, ADDR_EDGECAP, 32'h0,  0, 0, "b_glitch_ecap");
    in_b = 8'h08; cyc(6);
    rd_req(1, 1, ADDR_DATA,    32'h0,  0, 0, "b_deb_early");
    rd_req(1, 1, ADDR_DATA,    32'h08, 0, 0, "b_deb_lat");
    rd_req(1, 1, ADDR_EDGECAP, 32'h08, 1, 0, "b_ecap");

    // C: 32-bit any-edge capture and mask control of irq
    in_c = 32'hA5A5_A5A5; cyc(5);
    in_c = 32'h0; cyc(5);
    rd_req(2, 1, ADDR_EDGECAP, 32'hA5A5_A5A5, 1, 0, "c_any");
    rd_req(2, 1, ADDR_DATA,    32'h0,         0, 0, "c_data0");
    wr_req(2, ADDR_IRQMASK, 32'h1);
    rd_req(2, 1, ADDR_EDGECAP, 32'hA5A5_A5A5, 1, 1, "c_irq_on");
    wr_req(2, ADDR_EDGECAP, 32'hA5A5_A5A4);
    rd_req(2, 1, ADDR_EDGECAP, 32'h1,         1, 1, "c_partial_clr");
    wr_req(2, ADDR_EDGECAP, 32'h1);
    rd_req(2, 1, ADDR_EDGECAP, 32'h0,         1, 0, "c_all_clr");
    in_c = 32'hFFFF_0000; cyc(5);
    rd_req(2, 1, ADDR_EDGECAP, 32'hFFFF_0000, 0, 0, "c_rise_hi");
    wr_req(2, ADDR_EDGECAP, 32'hFFFF_FFFF);
    in_c = 32'h0; cyc(5);
    rd_req(2, 1, ADDR_EDGECAP, 32'hFFFF_0000, 1, 0, "c_fall_hi");

    cyc(3);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
